// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags.
// Holds one value and one alias per architectural register. Alias 0 means
// "not renamed"; x0 reads as zero and ignores all writes.
module reg_file #(
    parameter int REG_NUM      = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback_signal,
    input  logic                    res_rdy_from_rob,
    input  logic [4:0]              regidx_from_rob,
    input  logic [DATA_WIDTH-1:0]   res_from_rob,
    input  logic [ROB_ID_WIDTH-1:0] alias_from_rob,
    input  logic                    rename_ena_from_dsp,
    input  logic [4:0]              rename_rd_from_dsp,
    input  logic [ROB_ID_WIDTH-1:0] rename_id_from_dsp,
    input  logic [4:0]              rs1_from_dsp,
    input  logic [4:0]              rs2_from_dsp,
    output logic [DATA_WIDTH-1:0]   Vi_2dsp,
    output logic [ROB_ID_WIDTH-1:0] Qi_2dsp,
    output logic [DATA_WIDTH-1:0]   Vj_2dsp,
    output logic [ROB_ID_WIDTH-1:0] Qj_2dsp
);

    logic [DATA_WIDTH-1:0]   r_val [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] r_tag [REG_NUM];

    logic w_commit;
    logic w_rename;

    // Commit proceeds on rdy or during a rollback; rename only on a clean rdy cycle.
    assign w_commit = (rdy || rollback_signal) && res_rdy_from_rob &&
                      (regidx_from_rob != '0);
    assign w_rename = rdy && !rollback_signal && rename_ena_from_dsp &&
                      (rename_rd_from_dsp != '0);

    // A committing result is forwarded when its alias still owns the register.
    function automatic logic bypass_hit(input logic [4:0] idx);
        return res_rdy_from_rob && (regidx_from_rob == idx) &&
               (r_tag[idx] == alias_from_rob);
    endfunction

    // State update: rollback clears tags, commit writes value and retires a
    // matching tag, rename is issued last so it wins over a same-register commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            if (rollback_signal) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    r_tag[i] <= '0;
                end
            end
            if (w_commit) begin
                r_val[regidx_from_rob] <= res_from_rob;
                if (!rollback_signal && (r_tag[regidx_from_rob] == alias_from_rob)) begin
                    r_tag[regidx_from_rob] <= '0;
                end
            end
            if (w_rename) begin
                r_tag[rename_rd_from_dsp] <= rename_id_from_dsp;
            end
        end
    end

    // Source 1 query: pre-rename mapping plus commit bypass, forced to 0 in reset.
    always_comb begin
        Vi_2dsp = '0;
        Qi_2dsp = '0;
        if (rst && (rs1_from_dsp != '0)) begin
            if (bypass_hit(rs1_from_dsp)) begin
                Vi_2dsp = res_from_rob;
            end else begin
                Vi_2dsp = r_val[rs1_from_dsp];
                Qi_2dsp = r_tag[rs1_from_dsp];
            end
        end
    end

    // Source 2 query: same rules as source 1.
    always_comb begin
        Vj_2dsp = '0;
        Qj_2dsp = '0;
        if (rst && (rs2_from_dsp != '0)) begin
            if (bypass_hit(rs2_from_dsp)) begin
                Vj_2dsp = res_from_rob;
            end else begin
                Vj_2dsp = r_val[rs2_from_dsp];
                Qj_2dsp = r_tag[rs2_from_dsp];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed scenarios plus randomized traffic checked
// against an array-based reference model.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        res_rdy;
    logic [4:0]  regidx;
    logic [31:0] res;
    logic [3:0]  alias_id;
    logic        ren_ena;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_id;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] vi;
    logic [3:0]  qi;
    logic [31:0] vj;
    logic [3:0]  qj;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_val [32];
    logic [3:0]  m_tag [32];

    reg_file #(.REG_NUM(32), .DATA_WIDTH(32), .ROB_ID_WIDTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst_n),
        .rdy                 (rdy),
        .rollback_signal     (rollback),
        .res_rdy_from_rob    (res_rdy),
        .regidx_from_rob     (regidx),
        .res_from_rob        (res),
        .alias_from_rob      (alias_id),
        .rename_ena_from_dsp (ren_ena),
        .rename_rd_from_dsp  (ren_rd),
        .rename_id_from_dsp  (ren_id),
        .rs1_from_dsp        (rs1),
        .rs2_from_dsp        (rs2),
        .Vi_2dsp             (vi),
        .Qi_2dsp             (qi),
        .Vj_2dsp             (vj),
        .Qj_2dsp             (qj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the dispatcher should see for a source index right now.
    function automatic logic [35:0] model_query(input logic [4:0] r);
        if (!rst_n || r == 5'd0) return 36'd0;
        if (res_rdy && regidx == r && m_tag[r] == alias_id) return {res, 4'd0};
        return {m_val[r], m_tag[r]};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
    endfunction

    // Reference: state change at a rising edge, written from the behaviour rules.
    function automatic void model_edge();
        logic commit_ok;
        logic rename_ok;
        logic [3:0] old_tag;
        commit_ok = (rdy || rollback) && res_rdy && (regidx != 5'd0);
        rename_ok = rdy && !rollback && ren_ena && (ren_rd != 5'd0);
        old_tag   = m_tag[regidx];
        if (commit_ok) m_val[regidx] = res;
        if (rollback) begin
            for (int i = 0; i < 32; i++) m_tag[i] = '0;
        end else begin
            if (commit_ok && old_tag == alias_id) m_tag[regidx] = '0;
            if (rename_ok) m_tag[ren_rd] = ren_id;
        end
    endfunction

    task automatic check_ports();
        logic [35:0] e1;
        logic [35:0] e2;
        e1 = model_query(rs1);
        e2 = model_query(rs2);
        check("Vi", vi, e1[35:4]);
        check("Qi", {28'd0, qi}, {28'd0, e1[3:0]});
        check("Vj", vj, e2[35:4]);
        check("Qj", {28'd0, qj}, {28'd0, e2[3:0]});
    endtask

    task automatic tick();
        #1;
        check_ports();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0; res_rdy = 1'b0; regidx = '0; res = '0;
        alias_id = '0; ren_ena = 1'b0; ren_rd = '0; ren_id = '0;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] a);
        res_rdy = 1'b1; regidx = rd; res = v; alias_id = a;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] id);
        ren_ena = 1'b1; ren_rd = rd; ren_id = id;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        rs1 = 5'd5; rs2 = 5'd0;
        model_clear();
        // Reset state, including a commit that would otherwise bypass.
        #1;
        check("rst_Vi", vi, 32'd0);
        check("rst_Qi", {28'd0, qi}, 32'd0);
        check("rst_Vj", vj, 32'd0);
        check("rst_Qj", {28'd0, qj}, 32'd0);
        commit(5'd5, 32'h1234, 4'd0);
        #1;
        check("rst_byp_Vi", vi, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Rename then commit with bypass.
        rename(5'd3, 4'd2); tick();
        idle(); rs1 = 5'd3; #1;
        check("ren_Qi", {28'd0, qi}, 32'd2);
        commit(5'd3, 32'hDEADBEEF, 4'd2); #1;
        check("byp_Vi", vi, 32'hDEADBEEF);
        check("byp_Qi", {28'd0, qi}, 32'd0);
        tick();
        idle(); #1;
        check("cmt_Vi", vi, 32'hDEADBEEF);
        check("cmt_Qi", {28'd0, qi}, 32'd0);
        tick();

        // Younger rename survives an older commit.
        rename(5'd4, 4'd1); tick();
        idle(); rename(5'd4, 4'd5); tick();
        idle(); commit(5'd4, 32'd7, 4'd1); rs1 = 5'd4; #1;
        check("nobyp_Vi", vi, 32'd0);
        check("nobyp_Qi", {28'd0, qi}, 32'd5);
        tick();
        idle(); #1;
        check("young_Vi", vi, 32'd7);
        check("young_Qi", {28'd0, qi}, 32'd5);
        tick();

        // Same-cycle commit and rename of one register.
        rename(5'd6, 4'd3); tick();
        idle(); commit(5'd6, 32'd9, 4'd3); rename(5'd6, 4'd4); rs1 = 5'd0; tick();
        idle(); rs1 = 5'd6; #1;
        check("cr_Vi", vi, 32'd9);
        check("cr_Qi", {28'd0, qi}, 32'd4);
        tick();

        // Rollback with concurrent commit and dropped rename.
        idle(); rename(5'd1, 4'd2); tick();
        idle(); rename(5'd2, 4'd3); tick();
        idle(); rollback = 1'b1; commit(5'd7, 32'h100, 4'd1); rename(5'd8, 4'd4); tick();
        idle(); rs1 = 5'd1; rs2 = 5'd2; #1;
        check("rb_Qi_x1", {28'd0, qi}, 32'd0);
        check("rb_Qj_x2", {28'd0, qj}, 32'd0);
        rs1 = 5'd7; rs2 = 5'd8; #1;
        check("rb_Vi_x7", vi, 32'h100);
        check("rb_Qj_x8", {28'd0, qj}, 32'd0);
        rs1 = 5'd4; rs2 = 5'd6; #1;
        check("rb_Qi_x4", {28'd0, qi}, 32'd0);
        check("rb_Qj_x6", {28'd0, qj}, 32'd0);
        tick();

        // Stall: nothing changes.
        idle(); rdy = 1'b0; commit(5'd9, 32'h77, 4'd1); rename(5'd9, 4'd6); rs1 = 5'd9; tick();
        idle(); #1;
        check("stall_Vi", vi, 32'd0);
        check("stall_Qi", {28'd0, qi}, 32'd0);
        tick();

        // x0 stays zero.
        idle(); commit(5'd0, 32'h55, 4'd0); rename(5'd0, 4'd3); rs1 = 5'd0; rs2 = 5'd0; #1;
        check("x0_Vi_now", vi, 32'd0);
        tick();
        idle(); #1;
        check("x0_Vi", vi, 32'd0);
        check("x0_Qi", {28'd0, qi}, 32'd0);
        tick();

        // Randomized traffic against the model, with occasional async reset.
        for (int c = 0; c < 3000; c++) begin
            rdy      = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 24) == 0);
            res_rdy  = $urandom_range(0, 1);
            regidx   = 5'($urandom_range(0, 31));
            res      = $urandom;
            alias_id = ($urandom_range(0, 1) != 0) ? m_tag[regidx] : 4'($urandom_range(0, 15));
            ren_ena  = $urandom_range(0, 1);
            ren_rd   = ($urandom_range(0, 3) == 0) ? regidx : 5'($urandom_range(0, 31));
            ren_id   = 4'($urandom_range(1, 15));
            rs1      = ($urandom_range(0, 2) == 0) ? regidx : 5'($urandom_range(0, 31));
            rs2      = ($urandom_range(0, 2) == 0) ? ren_rd : 5'($urandom_range(0, 31));
            tick();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                check_ports();
                check("mid_rst_Vi", vi, 32'd0);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
